result_check: RTL and testbench

- Consumer-side counterpart of the matrix loader that supplies weights, data and expected result to the systolic array.
- Accepts the array's result matrix as a row-major element stream over a valid/ready handshake and compares each element against the expected packed matrix.
- Reports pass/fail, mismatch count and first mismatch index.
- Sits between the systolic array output and the board status LEDs / 7-segment display.

---
 rtl/systolic_pkg.sv | 27 ++
 rtl/rc_index_counter.sv | 69 ++++++
 rtl/result_check.sv | 181 ++++++++++++++++++
 tb/tb_result_check.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array, its matrix loader and the result
// checker: default dimensions, the result element type and the checker FSM
// state encoding.
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ARRAY_W_W_DEF  = 2;
    localparam int ARRAY_A_L_DEF  = 2;

    // Result elements are full-precision products/sums of two operands.
    typedef logic [2*DATA_WIDTH_DEF-1:0] res_elem_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rc_index_counter.sv
// -----------------------------------------------------------------------------
// rc_index_counter
// Row/column walker over a ROWS x COLS matrix in row-major order.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous reset, active-high
//   clear    in   synchronous restart of the walk at (0,0)
//   advance  in   step to the next element (col first, wrapping into row)
//   row      out  current row
//   col      out  current column
//   idx      out  current row-major index, row*COLS + col
//   last     out  current position is the final element (ROWS-1, COLS-1)
// -----------------------------------------------------------------------------
module rc_index_counter
    import systolic_pkg::*;
#(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int ROW_W = 1,
    parameter int COL_W = 1,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             row_end, col_end;

    assign row_end = (row_q == ROW_W'(ROWS - 1));
    assign col_end = (col_q == COL_W'(COLS - 1));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (advance) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign idx  = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);
    assign last = row_end && col_end;

endmodule

// File: rtl/result_check.sv
// -----------------------------------------------------------------------------
// result_check
// Consumes the systolic array's result matrix as a row-major element stream
// (valid/ready) and compares each element against an expected matrix that is
// latched when the run starts. Reports pass/fail, mismatch count and the
// row-major index of the first mismatch.
//
// Optional feature: define RESULT_CHECK_TIMEOUT_EN to enable a watchdog that
// ends the run (timeout=1, pass=0) after TIMEOUT_CYCLES cycles in RUN with no
// accepted element. Without it, RUN waits indefinitely and timeout is 0.
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous reset, active-high
//   start          in   single-cycle pulse starting a run (ignored in RUN)
//   expected       in   expected result matrix, packed row-major
//   res_valid      in   result element valid
//   res_data       in   result element
//   res_ready      out  element accepted this cycle when high (RUN only)
//   done           out  run complete; held until next start or reset
//   pass           out  no mismatches (and no timeout); valid when done=1
//   err_count      out  number of mismatching elements
//   first_err_idx  out  row-major index of the first mismatch, 0 if none
//   timeout        out  watchdog expired
// -----------------------------------------------------------------------------
module result_check
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int ARRAY_W_W      = ARRAY_W_W_DEF,
    parameter int ARRAY_A_L      = ARRAY_A_L_DEF,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int N     = ARRAY_W_W * ARRAY_A_L,
    localparam int IDX_W = idx_width(N),
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                start,
    input  logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0] expected,
    input  logic                                                res_valid,
    input  logic [2*DATA_WIDTH-1:0]                             res_data,
    output logic                                                res_ready,
    output logic                                                done,
    output logic                                                pass,
    output logic [CNT_W-1:0]                                    err_count,
    output logic [IDX_W-1:0]                                    first_err_idx,
    output logic                                                timeout
);

    localparam int ROW_W = idx_width(ARRAY_W_W);
    localparam int COL_W = idx_width(ARRAY_A_L);

    chk_state_t                                          state_q;
    logic [0:ARRAY_W_W-1][0:ARRAY_A_L-1][2*DATA_WIDTH-1:0] exp_q;
    logic                                                ready_q;
    logic                                                done_q;
    logic                                                pass_q;
    logic [CNT_W-1:0]                                    err_cnt_q, err_cnt_d;
    logic [IDX_W-1:0]                                    first_q;

    logic             hs;
    logic             mismatch;
    logic             start_run;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [IDX_W-1:0] idx;
    logic             last;

    // ready_q is only ever high in RUN, so a handshake implies RUN.
    assign hs        = res_valid && ready_q;
    assign start_run = start && (state_q != RUN);
    assign mismatch  = hs && (res_data != exp_q[row][col]);
    assign err_cnt_d = err_cnt_q + CNT_W'(mismatch);

    rc_index_counter #(
        .ROWS  (ARRAY_W_W),
        .COLS  (ARRAY_A_L),
        .ROW_W (ROW_W),
        .COL_W (COL_W),
        .IDX_W (IDX_W)
    ) u_idx (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_run),
        .advance (hs),
        .row     (row),
        .col     (col),
        .idx     (idx),
        .last    (last)
    );

`ifdef RESULT_CHECK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             timeout_q;
    logic             tmo_hit;

    // Fires on the TIMEOUT_CYCLES-th consecutive cycle in RUN without a handshake.
    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign timeout = timeout_q;
`else
    // Watchdog limit has no meaning without the watchdog.
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = |TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= '0;
            first_q   <= '0;
`ifdef RESULT_CHECK_TIMEOUT_EN
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        exp_q     <= expected;
                        state_q   <= RUN;
                        ready_q   <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        err_cnt_q <= '0;
                        first_q   <= '0;
`ifdef RESULT_CHECK_TIMEOUT_EN
                        tmo_cnt_q <= '0;
                        timeout_q <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    if (hs) begin
                        err_cnt_q <= err_cnt_d;
                        if (mismatch && (err_cnt_q == '0)) begin
                            first_q <= idx;
                        end
`ifdef RESULT_CHECK_TIMEOUT_EN
                        tmo_cnt_q <= '0;
`endif
                        // Final element: its comparison is folded into pass.
                        if (last) begin
                            state_q <= DONE;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_cnt_d == '0);
                        end
                    end
`ifdef RESULT_CHECK_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state_q   <= DONE;
                        ready_q   <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign res_ready     = ready_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_cnt_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_result_check.sv
module tb_result_check;

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic [0:1][0:1][15:0]  expected;
    logic                   res_valid;
    logic [15:0]            res_data;
    logic                   res_ready;
    logic                   done;
    logic                   pass;
    logic [2:0]             err_count;
    logic [1:0]             first_err_idx;
    logic                   timeout;

    result_check #(
        .DATA_WIDTH     (8),
        .ARRAY_W_W      (2),
        .ARRAY_A_L      (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .expected      (expected),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_ready     (res_ready),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pass;
        logic [2:0] err;
        logic [1:0] first;
        logic       tmo;
    } res_t;

    res_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic done_prev = 1'b0;

    logic [0:1][0:1][15:0] exp_mat;
    logic [15:0] good[4];
    logic [15:0] bad[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: on every rising edge of done, pop the next expected result.
    always @(negedge clk) begin
        if (done === 1'b1 && done_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = sb_q.pop_front();
                check("sb_pass",      pass,          e.pass);
                check("sb_err_count", err_count,     e.err);
                check("sb_first_idx", first_err_idx, e.first);
                check("sb_timeout",   timeout,       e.tmo);
            end
        end
        done_prev <= done;
    end

    task automatic do_start();
        @(negedge clk);
        res_valid = 1'b0;
        check("ready_before_start", res_ready, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ready_after_start", res_ready, 1'b1);
    endtask

    // Drives elements v[from..to-1]; a handshake happens on the posedge after
    // a negedge where valid is driven and ready (registered) is already high.
    task automatic send(input logic [15:0] v[4], input int from, input int to, input bit toggle);
        int i = from;
        int cyc = 0;
        bit gap = 1'b0;
        while (i < to && cyc < 100) begin
            @(negedge clk);
            if (gap) begin
                res_valid = 1'b0;
                gap = 1'b0;
            end else begin
                res_valid = 1'b1;
                res_data  = v[i];
                if (res_ready) begin
                    i++;
                    gap = toggle;
                end
            end
            cyc++;
        end
        @(negedge clk);
        res_valid = 1'b0;
        if (i < to) check("send_budget", i, to);
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (done !== 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"},   res_ready,     1'b0);
        check({tag, "_done"},    done,          1'b0);
        check({tag, "_pass"},    pass,          1'b0);
        check({tag, "_err"},     err_count,     3'd0);
        check({tag, "_first"},   first_err_idx, 2'd0);
        check({tag, "_timeout"}, timeout,       1'b0);
    endtask

    initial begin
        good = '{16'h003c, 16'h0046, 16'h0104, 16'h0140};
        bad  = '{16'h003c, 16'h0047, 16'h0104, 16'h0141};
        exp_mat   = {16'h003c, 16'h0046, 16'h0104, 16'h0140};
        expected  = exp_mat;
        reset     = 1'b1;
        start     = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_state("por");

        // All elements correct, valid held high.
        sb_q.push_back('{pass: 1'b1, err: 3'd0, first: 2'd0, tmo: 1'b0});
        do_start();
        send(good, 0, 4, 1'b0);
        wait_done(5);
        // DONE holds its outputs and ignores valid.
        res_valid = 1'b1;
        res_data  = 16'hdead;
        repeat (3) @(negedge clk);
        res_valid = 1'b0;
        check("done_held",     done,      1'b1);
        check("ready_in_done", res_ready, 1'b0);
        check("err_in_done",   err_count, 3'd0);

        // Two mismatches at indices 1 and 3.
        sb_q.push_back('{pass: 1'b0, err: 3'd2, first: 2'd1, tmo: 1'b0});
        do_start();
        send(bad, 0, 4, 1'b0);
        wait_done(5);

        // Toggling valid; expected input zeroed after start must not matter.
        sb_q.push_back('{pass: 1'b1, err: 3'd0, first: 2'd0, tmo: 1'b0});
        do_start();
        expected = '0;
        send(good, 0, 4, 1'b1);
        wait_done(5);
        expected = exp_mat;

        // Reset mid-run, then a clean run.
        do_start();
        send(good, 0, 2, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("midrun_rst");
        sb_q.push_back('{pass: 1'b1, err: 3'd0, first: 2'd0, tmo: 1'b0});
        do_start();
        send(good, 0, 4, 1'b0);
        wait_done(5);

        // start pulsed in RUN after one handshake is ignored.
        sb_q.push_back('{pass: 1'b1, err: 3'd0, first: 2'd0, tmo: 1'b0});
        do_start();
        send(good, 0, 1, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send(good, 1, 4, 1'b0);
        wait_done(2);

`ifdef RESULT_CHECK_TIMEOUT_EN
        sb_q.push_back('{pass: 1'b0, err: 3'd0, first: 2'd0, tmo: 1'b1});
        do_start();
        send(good, 0, 1, 1'b0);
        repeat (14) @(negedge clk);
        check("no_early_timeout", done, 1'b0);
        @(negedge clk);
        check("timeout_done",  done,    1'b1);
        check("timeout_flag",  timeout, 1'b1);
`else
        do_start();
        send(good, 0, 1, 1'b0);
        repeat (40) @(negedge clk);
        check("no_watchdog_done",    done,      1'b0);
        check("no_watchdog_timeout", timeout,   1'b0);
        check("no_watchdog_ready",   res_ready, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
